// File: rtl/microseq.sv
// Microprogram sequencer for the multicycle MIPS control unit, plus retire/illegal-opcode bookkeeping.
// All outputs registered (1-cycle latency); stall freezes state and counters and suppresses pulses.
module microseq #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [5:0]       i_opcode,
  input  logic [1:0]       i_addrctl,
  input  logic             i_stall,
  output logic [3:0]       o_state,
  output logic             o_retire,
  output logic             o_illegal_op,
  output logic [CNT_W-1:0] o_instr_count,
  output logic [CNT_W-1:0] o_illegal_count
);

  localparam logic [3:0] FETCH   = 4'd0;
  localparam logic [3:0] DECODE  = 4'd1;
  localparam logic [3:0] MEMADR  = 4'd2;
  localparam logic [3:0] MEMRD   = 4'd3;
  localparam logic [3:0] MEMWB   = 4'd4;
  localparam logic [3:0] MEMWR   = 4'd5;
  localparam logic [3:0] RTYPEEX = 4'd6;
  localparam logic [3:0] RTYPEWB = 4'd7;
  localparam logic [3:0] BEQEX   = 4'd8;
  localparam logic [3:0] JEX     = 4'd9;

  localparam logic [1:0] AC_FETCH = 2'b00;
  localparam logic [1:0] AC_DISP1 = 2'b01;
  localparam logic [1:0] AC_DISP2 = 2'b10;
  localparam logic [1:0] AC_INCR  = 2'b11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic [3:0]       r_state;
  logic             r_retire;
  logic             r_illegal;
  logic [CNT_W-1:0] r_instr_count;
  logic [CNT_W-1:0] r_illegal_count;

  logic [3:0]       w_next;
  logic             w_retire;
  logic             w_illegal;
  logic             w_valid_state;

  assign w_valid_state = (r_state <= JEX);

  always_comb begin
    w_next    = FETCH;
    w_illegal = 1'b0;
    w_retire  = 1'b0;
    // Unreachable addresses 10-15 fall through to FETCH without retiring.
    if (w_valid_state) begin
      case (i_addrctl)
        AC_FETCH: begin
          w_next   = FETCH;
          w_retire = (r_state != FETCH);
        end
        AC_INCR: w_next = r_state + 4'd1;
        AC_DISP1: begin
          case (i_opcode)
            OP_RTYPE: w_next = RTYPEEX;
            OP_LW:    w_next = MEMADR;
            OP_SW:    w_next = MEMADR;
            OP_BEQ:   w_next = BEQEX;
            OP_J:     w_next = JEX;
            default: begin
              w_next    = FETCH;
              w_illegal = 1'b1;
            end
          endcase
        end
        AC_DISP2: begin
          case (i_opcode)
            OP_LW:   w_next = MEMRD;
            OP_SW:   w_next = MEMWR;
            default: w_next = FETCH;
          endcase
        end
        default: w_next = FETCH;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state         <= FETCH;
      r_retire        <= 1'b0;
      r_illegal       <= 1'b0;
      r_instr_count   <= '0;
      r_illegal_count <= '0;
    end else if (i_stall) begin
      r_retire  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_retire  <= w_retire;
      r_illegal <= w_illegal;
      if (w_retire)
        r_instr_count <= r_instr_count + 1'b1;
      if (w_illegal && (r_illegal_count != {CNT_W{1'b1}}))
        r_illegal_count <= r_illegal_count + 1'b1;
    end
  end

  assign o_state         = r_state;
  assign o_retire        = r_retire;
  assign o_illegal_op    = r_illegal;
  assign o_instr_count   = r_instr_count;
  assign o_illegal_count = r_illegal_count;

endmodule

// File: doc/microseq.md
Name: microseq

Overview:
- Microprogram sequencer for the multicycle MIPS control unit.
- Produces the 4-bit `state` address that indexes the microinstruction control store.
- Consumes the store's sequencing field (`addrctl`) and the instruction opcode, and selects the next micro-address by fetch-return, dispatch table 1, dispatch table 2, or increment.
- Also keeps retired-instruction and illegal-opcode bookkeeping for the bench and debug.

Parameters:
- CNT_W, 16, width of the retired-instruction and illegal-opcode counters.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- opcode  input  6  instr[31:26] from the instruction register; stable while state != FETCH.
- addrctl  input  2  sequencing field of the current microinstruction: 00 = fetch, 01 = dispatch1, 10 = dispatch2, 11 = increment.
- stall  input  1  memory not ready; freezes the sequencer.
- state  output  4  current micro-address, registered; drives the control store.
- retire  output  1  one-cycle pulse on the cycle an instruction completes.
- illegal_op  output  1  one-cycle pulse when dispatch1 sees an unsupported opcode.
- instr_count  output  CNT_W  count of retired instructions; wraps.
- illegal_count  output  CNT_W  count of illegal opcodes; saturates at all-ones.

Behaviour:
- Reset (async, any time, including mid-instruction):
  - state = 0 (FETCH), retire = 0, illegal_op = 0, instr_count = 0, illegal_count = 0.
  - The first rising edge after reset deasserts begins sequencing from FETCH.
- Micro-addresses:
  - 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMRD, 4 MEMWB, 5 MEMWR, 6 RTYPEEX, 7 RTYPEWB, 8 BEQEX, 9 JEX.
  - Values 10-15 are unreachable. If one is ever held, the next unstalled edge goes to FETCH regardless of addrctl.
- Next-address selection, on each rising edge with stall = 0:
  - addrctl = 00: next = FETCH.
  - addrctl = 11: next = state + 1, 4-bit. State 15 wraps to 0.
  - addrctl = 01 (dispatch1, keyed on opcode):
    - 000000 R-type -> 6
    - 100011 lw -> 2
    - 101011 sw -> 2
    - 000100 beq -> 8
    - 000010 j -> 9
    - any other opcode -> FETCH, with illegal_op = 1 for the following cycle.
  - addrctl = 10 (dispatch2, keyed on opcode):
    - 100011 -> 3
    - 101011 -> 5
    - any other opcode -> FETCH. No illegal_op pulse; dispatch2 is only reachable through dispatch1.
- Stall:
  - stall = 1 at a rising edge: state, both counters and all state-derived logic hold.
  - retire and illegal_op are forced to 0 on the following cycle, so pulses are never stretched.
  - Stall has no effect on reset.
- Retire:
  - Asserted for exactly one cycle after an unstalled edge that moves state from a non-FETCH address to FETCH via addrctl = 00.
  - Illegal-opcode and unreachable-address returns to FETCH do not retire.
  - instr_count increments by 1 on that same edge and wraps from all-ones to 0.
- Illegal opcode:
  - illegal_count increments on the same edge that sets the illegal_op pulse.
  - It holds at all-ones once saturated.
- Timing: all outputs are registered with zero combinational path from inputs, giving one-cycle latency from addrctl/opcode to state.
- Simultaneous events: reset dominates stall, which dominates sequencing. Retire and illegal_op are mutually exclusive by construction.
- Expected path lengths with the standard control store, stall = 0:
  - lw 5 cycles (0,1,2,3,4)
  - sw 4 cycles (0,1,2,5)
  - R-type 4 cycles (0,1,6,7)
  - beq 3 cycles (0,1,8)
  - j 3 cycles (0,1,9)

Test Plan:
- Reset mid-instruction:
  - Stimulus: reach state 3, then assert reset asynchronously between edges.
  - Required: state = 0 and both counters = 0 immediately, without waiting for a clock edge.
- lw sequence:
  - Stimulus: opcode = 100011; drive addrctl per state as 11, 01, 10, 11, 00.
  - Required: states 0,1,2,3,4,0; one retire pulse; instr_count = 1.
- Mixed program:
  - Stimulus: sw, R-type, beq, j back-to-back.
  - Required: paths 0,1,2,5 / 0,1,6,7 / 0,1,8 / 0,1,9; instr_count = 4 after 14 cycles.
- Illegal opcode:
  - Stimulus: opcode = 111111 at DECODE with addrctl = 01.
  - Required: next state = 0; illegal_op high for exactly 1 cycle; illegal_count = 1; retire stays 0; instr_count unchanged.
- Stall:
  - Stimulus: assert stall for 3 cycles while in state 3, on the cycle before the 4->0 transition.
  - Required: state stays 3 for 3 cycles, then resumes to 4 and 0; retire is a single 1-cycle pulse; count increments once.
- Counter wrap and saturate:
  - Setup: CNT_W = 4.
  - Stimulus: retire 16 instructions; separately, issue 20 illegal opcodes.
  - Required: instr_count reads 0 after the 16th retire; illegal_count holds at 15.
